// File: rtl/carregador_programa.sv
// Program loader: receives a 16-bit word count followed by MSB-first byte
// quadruples and issues one memory write per assembled 32-bit word.
module carregador_programa #(
  parameter int BASE    = 0,
  parameter int DEPTH   = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] dado,
  output logic [9:0]  endereco,
  output logic        write,
  output logic        busy,
  output logic        done,
  output logic        erro
);

  localparam int              TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [9:0]      BASE_ADDR = 10'(BASE);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, BYTES, WRITE, FIM, ERRO} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_cnt_hi;
  logic [15:0]   r_n;
  logic [15:0]   r_k;
  logic [1:0]    r_idx;
  logic [31:0]   r_word;
  logic [9:0]    r_end;
  logic [TW-1:0] r_to;
  logic          r_erro;

  logic          w_acc;
  logic          w_timeout;
  logic [15:0]   w_n;
  logic          w_bad_n;
  logic [15:0]   w_k_inc;

  assign w_acc     = byte_valid && byte_ready;
  assign w_timeout = !w_acc && (r_to == TO_LAST);
  assign w_n       = {r_cnt_hi, byte_in};
  assign w_bad_n   = (w_n == '0) || ((32'(BASE) + {16'b0, w_n}) > 32'(DEPTH));
  assign w_k_inc   = r_k + 16'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CNT_HI;
      CNT_HI:  if (w_acc) w_next = CNT_LO;
               else if (w_timeout) w_next = ERRO;
      CNT_LO:  if (w_acc) w_next = w_bad_n ? ERRO : BYTES;
               else if (w_timeout) w_next = ERRO;
      BYTES:   if (w_acc && (r_idx == 2'd3)) w_next = WRITE;
               else if (w_timeout) w_next = ERRO;
      WRITE:   w_next = (w_k_inc == r_n) ? FIM : BYTES;
      FIM:     w_next = IDLE;
      ERRO:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    write      = 1'b0;
    done       = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      CNT_HI, CNT_LO, BYTES: byte_ready = 1'b1;
      WRITE:                 write      = 1'b1;
      FIM:                   done       = 1'b1;
      default:               ;
    endcase
  end

  // The address is held on the final word so it never passes BASE+N-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_hi <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      r_end    <= BASE_ADDR;
      r_to     <= '0;
      r_erro   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_erro <= 1'b0;
          r_k    <= '0;
          r_idx  <= '0;
          r_to   <= '0;
          r_end  <= BASE_ADDR;
        end
        CNT_HI, CNT_LO, BYTES: begin
          r_to <= w_acc ? '0 : r_to + 1'b1;
          if (w_acc) begin
            if (r_state == CNT_HI) r_cnt_hi <= byte_in;
            if (r_state == CNT_LO) r_n      <= w_n;
            if (r_state == BYTES) begin
              r_word <= {r_word[23:0], byte_in};
              r_idx  <= r_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          r_k <= w_k_inc;
          if (w_k_inc != r_n) r_end <= r_end + 10'd1;
        end
        default: ;
      endcase
      if (w_next == ERRO) r_erro <= 1'b1;
    end
  end

  assign dado     = r_word;
  assign endereco = r_end;
  assign erro     = r_erro;

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: nominal load, valid gaps, bad counts,
// timeout, reset mid-load and start while busy.
module tb_carregador_programa;

  localparam int TO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] dado;
  logic [9:0]  endereco;
  logic        write;
  logic        busy;
  logic        done;
  logic        erro;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int overlap  = 0;
  int wr_base;

  carregador_programa #(.BASE(0), .DEPTH(128), .TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .dado       (dado),
    .endereco   (endereco),
    .write      (write),
    .busy       (busy),
    .done       (done),
    .erro       (erro)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (write) wr_count++;
    if (write && done) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready) chk("ready_wait", byte_ready, 1);
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
    if (gap) @(negedge clock);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("erro_clear", erro, 0);
    chk("ready_cnt_hi", byte_ready, 1);
  endtask

  task automatic check_write(input logic [9:0] addr, input logic [31:0] w);
    @(negedge clock);
    chk("write", write, 1);
    chk("endereco", endereco, addr);
    chk("dado", dado, w);
  endtask

  task automatic check_finish();
    @(negedge clock);
    chk("done", done, 1);
    chk("write_off", write, 0);
    @(negedge clock);
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("erro_end", erro, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [9:0] addr, input bit gap, input bit last);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = w >> (8 * (3 - i));
      send_byte(t[7:0], gap && (i < 3));
    end
    check_write(addr, w);
    if (last) check_finish();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", byte_ready, 0);
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_erro", erro, 0);
    chk("rst_dado", dado, 0);
    chk("rst_end", endereco, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_wait", busy, 0);

    // nominal two-word load
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h041F01CD, 10'd0, 0, 0);
    send_word(32'h5400001B, 10'd1, 0, 1);
    chk("nom_wr_count", wr_count - wr_base, 2);

    // byte_valid toggling
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_word(32'hDEADBEEF, 10'd0, 1, 1);
    chk("gap_wr_count", wr_count - wr_base, 1);

    // zero count
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_idle();
    chk("zero_erro", erro, 1);
    chk("zero_wr_count", wr_count - wr_base, 0);

    // count beyond DEPTH
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h81, 0);
    wait_idle();
    chk("big_erro", erro, 1);
    chk("big_wr_count", wr_count - wr_base, 0);

    // timeout after 2 bytes of word 1
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 10'd0, 0, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    repeat (TO) @(negedge clock);
    chk("to_not_early_erro", erro, 0);
    chk("to_not_early_busy", busy, 1);
    @(negedge clock);
    chk("to_erro", erro, 1);
    @(negedge clock);
    chk("to_busy", busy, 0);
    chk("to_erro_hold", erro, 1);
    repeat (5) @(negedge clock);
    chk("to_wr_count", wr_count - wr_base, 1);

    // exact-fit count, then reset between bytes 3 and 4
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h80, 0);
    @(negedge clock);
    chk("fit_ready", byte_ready, 1);
    chk("fit_erro", erro, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_dado", dado, 0);
    chk("mid_rst_end", endereco, 0);
    chk("mid_rst_erro", erro, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("mid_rst_wr_count", wr_count - wr_base, 0);
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h01020304, 10'd0, 0, 1);

    // start pulsed during BYTES
    wr_base = wr_count;
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("sb_busy", busy, 1);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    check_write(10'd0, 32'h12345678);
    check_finish();
    chk("sb_wr_count", wr_count - wr_base, 1);

    chk("write_done_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 The block SHALL have parameter BASE, default 0, the memory word address of the first loaded word.
REQ-002 The block SHALL have parameter DEPTH, default 128, the number of memory words available.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, the maximum idle cycles allowed between accepted bytes.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: a level sampled in IDLE that begins a load.
REQ-007 The block SHALL have port byte_in, input, 8 bits: the incoming program byte.
REQ-008 The block SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-009 The block SHALL have port byte_ready, output, 1 bit: the block accepts byte_in this cycle.
REQ-010 The block SHALL have port dado, output, 32 bits: the word to write to memory.
REQ-011 The block SHALL have port endereco, output, 10 bits: the memory word address.
REQ-012 The block SHALL have port write, output, 1 bit: the memory write strobe, one cycle per word.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse on successful completion.
REQ-015 The block SHALL have port erro, output, 1 bit: sticky error flag, cleared at the next accepted start.

Function
REQ-016 A byte SHALL be accepted only on a rising edge where byte_valid=1 and byte_ready=1.
REQ-017 byte_ready SHALL be 1 only in states CNT_HI, CNT_LO and BYTES, and 0 in all other states.
REQ-018 The FSM SHALL have exactly the states IDLE, CNT_HI, CNT_LO, BYTES, WRITE, FIM and ERRO.
REQ-019 From IDLE, start=1 SHALL move the FSM to CNT_HI and clear erro, the word counter, the byte index and the timeout counter.
REQ-020 CNT_HI SHALL accept the upper count byte and move to CNT_LO.
REQ-021 CNT_LO SHALL accept the lower count byte, forming the 16-bit word count N.
REQ-022 In CNT_LO, if N=0 or BASE+N>DEPTH, the FSM SHALL move to ERRO; otherwise it SHALL move to BYTES.
REQ-023 In BYTES, each accepted byte SHALL be shifted into a 32-bit assembly register MSB-first (first byte becomes bits 31:24).
REQ-024 In BYTES, the FSM SHALL move to WRITE on the 4th accepted byte of a word.
REQ-025 In WRITE, write=1 SHALL be asserted for exactly one cycle, with dado = assembled word and endereco = BASE + k, where k = 0..N-1 is the word index.
REQ-026 dado and endereco SHALL be held stable through the WRITE cycle.
REQ-027 Latency: write SHALL assert in the cycle immediately after the 4th byte of a word is accepted.
REQ-028 After WRITE, k SHALL increment; if k+1 = N the FSM SHALL move to FIM, otherwise back to BYTES.
REQ-029 FIM SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-030 ERRO SHALL set erro=1 and return to IDLE on the next cycle; erro SHALL hold until the next start.
REQ-031 The timeout counter SHALL reset on each accepted byte and increment each cycle in CNT_HI, CNT_LO and BYTES without an accepted byte.
REQ-032 When the timeout counter reaches TIMEOUT, the FSM SHALL move to ERRO, discarding any partial word; words already written SHALL remain in memory.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 byte_valid with byte_ready=0 SHALL NOT consume the byte.
REQ-035 endereco SHALL be computed in 10 bits; REQ-022 guarantees it never exceeds BASE+DEPTH-1, so no wrap-around occurs.
REQ-036 write and done SHALL never assert simultaneously.

Reset
REQ-037 reset=0 SHALL immediately force: FSM=IDLE, byte_ready=0, write=0, busy=0, done=0, erro=0, dado=0, endereco=BASE, and all counters to 0.
REQ-038 Reset during a load SHALL abort the load with no further write; memory contents already written are unaffected.
REQ-039 After reset is released, the block SHALL wait in IDLE for start.

Verification
REQ-040 Scenario nominal load: start, bytes 00 02 04 1F 01 CD 54 00 00 1B -> write at endereco 0 with dado 0x041F01CD, then endereco 1 with 0x5400001B, then done pulse, erro=0.
REQ-041 Scenario byte_valid gaps: byte_valid toggling 1/0 each cycle during a 1-word load -> identical single write, no erro.
REQ-042 Scenario bad count: count 00 00 -> erro=1, no write; count 00 81 with DEPTH=128 -> erro=1, no write.
REQ-043 Scenario timeout: stop bytes after 2 of 4 bytes of word 1 for TIMEOUT cycles -> erro=1, busy=0, word 0 written, word 1 never written.
REQ-044 Scenario reset mid-load: assert reset=0 between bytes 3 and 4 of word 0 -> all outputs at reset values, no write; a following full load succeeds.
REQ-045 Scenario start while busy: pulse start during BYTES -> ignored, load completes normally, erro remains 0.
